// File: rtl/seq_stim_pkg.sv
// State encoding for the a-then-b sequence stimulus generator.
// Shared by the generator and anything that decodes its state.
package seq_stim_pkg;

  localparam logic [2:0] ENC_IDLE   = 3'd0;
  localparam logic [2:0] ENC_SEND_A = 3'd1;
  localparam logic [2:0] ENC_SEND_B = 3'd2;
  localparam logic [2:0] ENC_CHECK  = 3'd3;
  localparam logic [2:0] ENC_GAP    = 3'd4;
  localparam logic [2:0] ENC_DONE   = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = ENC_IDLE,
    SEND_A = ENC_SEND_A,
    SEND_B = ENC_SEND_B,
    CHECK  = ENC_CHECK,
    GAP    = ENC_GAP,
    DONE   = ENC_DONE
  } stim_state_t;

endpackage

// File: rtl/seq_stim_gen.sv
// Sends count a->b pairs with a gap of idle cycles and scores the detector's q per pair.
// Pair period is 3+gap cycles; start is honoured only in IDLE, all outputs registered.
module seq_stim_gen
  import seq_stim_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic [GAP_W-1:0] gap,
  input  logic             q_in,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sent_cnt,
  output logic [CNT_W-1:0] pass_cnt,
  output logic             fail
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [GAP_W-1:0] GAP_ONE = 1;

  stim_state_t      state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0] sent_cnt_q, sent_cnt_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic             fail_q, fail_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             last_pair;

  assign last_pair = (sent_cnt_q == count_q);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    gap_d      = gap_q;
    gap_cnt_d  = gap_cnt_q;
    sent_cnt_d = sent_cnt_q;
    pass_cnt_d = pass_cnt_q;
    fail_d     = fail_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          count_d    = count;
          gap_d      = gap;
          sent_cnt_d = '0;
          pass_cnt_d = '0;
          fail_d     = 1'b0;
          state_d    = (count == '0) ? DONE : SEND_A;
        end
      end
      SEND_A: begin
        // The detector must be quiet here; a high q is a spurious detect.
        if (q_in) fail_d = 1'b1;
        state_d = SEND_B;
      end
      SEND_B: begin
        if (sent_cnt_q != '1) sent_cnt_d = sent_cnt_q + CNT_ONE;
        state_d = CHECK;
      end
      CHECK: begin
        if (q_in) begin
          if (pass_cnt_q != '1) pass_cnt_d = pass_cnt_q + CNT_ONE;
        end else begin
          fail_d = 1'b1;
        end
        if (gap_q != '0) begin
          gap_cnt_d = gap_q - GAP_ONE;
          state_d   = GAP;
        end else begin
          state_d = last_pair ? DONE : SEND_A;
        end
      end
      GAP: begin
        if (q_in) fail_d = 1'b1;
        if (gap_cnt_q == '0) begin
          state_d = last_pair ? DONE : SEND_A;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_ONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they are registered yet line up with it.
    a_d    = (state_d == SEND_A);
    b_d    = (state_d == SEND_B);
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      gap_q      <= '0;
      gap_cnt_q  <= '0;
      sent_cnt_q <= '0;
      pass_cnt_q <= '0;
      fail_q     <= 1'b0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      gap_q      <= gap_d;
      gap_cnt_q  <= gap_cnt_d;
      sent_cnt_q <= sent_cnt_d;
      pass_cnt_q <= pass_cnt_d;
      fail_q     <= fail_d;
      a_q        <= a_d;
      b_q        <= b_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign a        = a_q;
  assign b        = b_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign sent_cnt = sent_cnt_q;
  assign pass_cnt = pass_cnt_q;
  assign fail     = fail_q;

endmodule

// File: tb/tb_seq_stim_gen.sv
// Scoreboard bench for seq_stim_gen: per-cycle a/b/busy/done and per-run result records.
module tb_seq_stim_gen;

  localparam int CNT_W = 8;
  localparam int GAP_W = 4;
  localparam int PAT_N = 5000;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] count;
  logic [GAP_W-1:0] gap;
  logic             q_in;
  logic             a, b, busy, done, fail;
  logic [CNT_W-1:0] sent_cnt, pass_cnt;

  typedef struct packed {
    logic a;
    logic b;
    logic busy;
    logic done;
  } cyc_t;

  typedef struct {
    int sent;
    int pass;
    int fail;
  } res_t;

  cyc_t exp_q[$];
  res_t res_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  bit   use_det;
  logic q_pat_val;
  bit   q_pat [0:PAT_N-1];
  logic det_a, det_q;

  seq_stim_gen #(.CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk(clk), .reset(reset), .start(start), .count(count), .gap(gap), .q_in(q_in),
    .a(a), .b(b), .busy(busy), .done(done),
    .sent_cnt(sent_cnt), .pass_cnt(pass_cnt), .fail(fail)
  );

  always #5 clk = ~clk;

  // Reference detector: q is high the cycle after seeing b one cycle after a.
  always @(posedge clk) begin
    if (reset) begin
      det_a <= 1'b0;
      det_q <= 1'b0;
    end else begin
      det_a <= a;
      det_q <= det_a & b;
    end
  end

  always_comb q_in = use_det ? det_q : q_pat_val;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected per-cycle outputs from the run arithmetic; cycle 1 is the cycle after start.
  function automatic cyc_t exp_at(input int c, input int cnt, input int gp, input int rst_at);
    int   p;
    int   total;
    cyc_t e;
    p     = 3 + gp;
    total = cnt * p + 1;
    e     = '0;
    if (rst_at > 0 && c > rst_at) return e;
    if (c == total) begin
      e.busy = 1'b1;
      e.done = 1'b1;
    end else if (c >= 1 && c < total) begin
      e.busy = 1'b1;
      e.a    = (((c - 1) % p) == 0);
      e.b    = (((c - 1) % p) == 1);
    end
    return e;
  endfunction

  always @(negedge clk) begin
    cyc_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("a", int'(a), int'(e.a));
      chk("b", int'(b), int'(e.b));
      chk("busy", int'(busy), int'(e.busy));
      chk("done", int'(done), int'(e.done));
    end
    if (done === 1'b1) begin
      if (res_q.size() == 0) begin
        chk("unexpected_done", int'(done), 0);
      end else begin
        res_t r;
        r = res_q.pop_front();
        chk("sent_cnt", int'(sent_cnt), r.sent);
        chk("pass_cnt", int'(pass_cnt), r.pass);
        chk("fail", int'(fail), r.fail);
      end
    end
  end

  // mode: 0 reference detector, 1 q tied low, 2 random q, 3 preloaded q pattern.
  task automatic run(input int cnt, input int gp, input int mode, input int restart_at,
                     input int rst_at);
    int   p;
    int   total;
    int   ncyc;
    int   base;
    res_t r;
    p     = 3 + gp;
    total = cnt * p + 1;
    use_det = (mode == 0);
    if (mode == 1 || mode == 2) begin
      for (int i = 0; i < PAT_N; i++) q_pat[i] = (mode == 2) ? ($urandom_range(0, 99) < 25) : 1'b0;
      if (mode == 2)
        for (int k = 0; k < cnt; k++) q_pat[1 + k * p + 2] = ($urandom_range(0, 99) < 75);
    end
    r.sent = cnt;
    r.pass = 0;
    r.fail = 0;
    if (mode == 0) begin
      r.pass = cnt;
    end else begin
      for (int k = 0; k < cnt; k++) begin
        base = 1 + k * p;
        if (q_pat[base]) r.fail = 1;
        if (q_pat[base + 2]) r.pass++;
        else r.fail = 1;
        for (int g = 1; g <= gp; g++) if (q_pat[base + 2 + g]) r.fail = 1;
      end
    end

    start     = 1'b1;
    count     = CNT_W'(cnt);
    gap       = GAP_W'(gp);
    q_pat_val = q_pat[0];
    @(posedge clk);
    #1;
    start = 1'b0;
    ncyc  = (rst_at > 0) ? rst_at + 3 : total + 1;
    for (int c = 1; c <= ncyc; c++) exp_q.push_back(exp_at(c, cnt, gp, rst_at));
    if (rst_at == 0) res_q.push_back(r);

    for (int c = 1; c <= ncyc; c++) begin
      q_pat_val = q_pat[c];
      start     = (c == restart_at);
      if (c == restart_at) count = count + CNT_W'(5);
      reset     = (c == rst_at);
      @(posedge clk);
      #1;
    end
    start     = 1'b0;
    reset     = 1'b0;
    q_pat_val = 1'b0;

    chk("exp_drained", exp_q.size(), 0);
    chk("res_drained", res_q.size(), 0);
    if (rst_at > 0) begin
      chk("rst_sent_cnt", int'(sent_cnt), 0);
      chk("rst_pass_cnt", int'(pass_cnt), 0);
      chk("rst_fail", int'(fail), 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: got no end of run, expected bench completion");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    int gp;
    int md;
    int rs;
    reset     = 1'b1;
    start     = 1'b0;
    count     = '0;
    gap       = '0;
    use_det   = 1'b1;
    q_pat_val = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_a", int'(a), 0);
    chk("reset_b", int'(b), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_fail", int'(fail), 0);
    chk("reset_sent", int'(sent_cnt), 0);
    chk("reset_pass", int'(pass_cnt), 0);

    run(3, 0, 0, 0, 0);
    run(2, 2, 1, 0, 0);
    run(0, 0, 0, 0, 0);
    for (int i = 0; i < PAT_N; i++) q_pat[i] = 1'b0;
    q_pat[3] = 1'b1;
    q_pat[5] = 1'b1;
    run(1, 3, 3, 0, 0);
    run(4, 0, 0, 3, 5);
    run(2, 1, 0, 9, 0);
    run(255, 0, 0, 0, 0);

    for (int n = 0; n < 14; n++) begin
      cnt = $urandom_range(0, 20);
      gp  = $urandom_range(0, 15);
      md  = $urandom_range(0, 2);
      rs  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, cnt * (3 + gp) + 1) : 0;
      run(cnt, gp, md, rs, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
